// File: rtl/poly_eval_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// poly_sched_pkg
//   Shared definitions for the polynomial datapath scheduler:
//   - state_t     : scheduler FSM states (load phase, compute phase, response)
//   - SEL_*       : datapath ALU operand select codes
//   - ALU_*       : datapath ALU operation codes
//   - OFF_*       : bit offsets of the 8-bit fields inside a packed job bundle
//   - op_field()  : extracts one 8-bit field from a packed job bundle
// -----------------------------------------------------------------------------
package poly_sched_pkg;

    localparam int DATA_W = 8;
    localparam int OPND_W = 32;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD_A = 4'd1,
        LOAD_B = 4'd2,
        LOAD_C = 4'd3,
        LOAD_X = 4'd4,
        CYC0   = 4'd5,
        CYC1   = 4'd6,
        CYC2   = 4'd7,
        CYC3   = 4'd8,
        CYC4   = 4'd9,
        RESP   = 4'd10
    } state_t;

    // ALU operand select codes understood by the datapath
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_X = 2'b11;

    // ALU operation codes
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_MUL = 1'b1;

    // Job bundle packing: {x[31:24], C[23:16], B[15:8], A[7:0]}
    localparam int OFF_A = 0;
    localparam int OFF_B = 8;
    localparam int OFF_C = 16;
    localparam int OFF_X = 24;

    function automatic logic [DATA_W-1:0] op_field(input logic [OPND_W-1:0] ops,
                                                   input int              off);
        return ops[off +: DATA_W];
    endfunction

endpackage

// File: rtl/poly_eval_scheduler_if.sv
// -----------------------------------------------------------------------------
// poly_eval_scheduler_if
//   Bundles every bus the scheduler talks over:
//   - two job request channels (req0_*, req1_*), 32-bit packed operands
//   - one result response channel (resp_*), 8-bit data plus requester id
//   - the control/observation lines of the shared polynomial datapath (dp_*)
//
//   Handshake rule used on every channel: a transfer happens on a rising clock
//   edge where valid and ready are both high. The source keeps valid high and
//   its payload stable until that edge; ready may depend combinationally on
//   valid; after the transfer the source may drop valid or present new data.
//
//   Modports:
//   - slave  : the scheduler's view (accepts jobs, produces responses,
//              drives the datapath controls, reads the datapath result)
//   - master : the surrounding system's view (requesters, consumer, datapath)
// -----------------------------------------------------------------------------
interface poly_eval_scheduler_if;

    // request channel 0
    logic        req0_valid;
    logic [31:0] req0_operands;
    logic        req0_ready;

    // request channel 1
    logic        req1_valid;
    logic [31:0] req1_operands;
    logic        req1_ready;

    // response channel
    logic        resp_valid;
    logic        resp_id;
    logic [7:0]  resp_data;
    logic        resp_ready;

    // datapath control and observation
    logic [7:0]  dp_data_in;
    logic        dp_ld_a;
    logic        dp_ld_b;
    logic        dp_ld_c;
    logic        dp_ld_x;
    logic        dp_ld_r;
    logic        dp_ld_alu_out;
    logic [1:0]  dp_alu_select_a;
    logic [1:0]  dp_alu_select_b;
    logic        dp_alu_op;
    logic [7:0]  dp_result;

    modport slave (
        input  req0_valid, req0_operands,
        output req0_ready,
        input  req1_valid, req1_operands,
        output req1_ready,
        output resp_valid, resp_id, resp_data,
        input  resp_ready,
        output dp_data_in, dp_ld_a, dp_ld_b, dp_ld_c, dp_ld_x, dp_ld_r,
        output dp_ld_alu_out, dp_alu_select_a, dp_alu_select_b, dp_alu_op,
        input  dp_result
    );

    modport master (
        output req0_valid, req0_operands,
        input  req0_ready,
        output req1_valid, req1_operands,
        input  req1_ready,
        input  resp_valid, resp_id, resp_data,
        output resp_ready,
        input  dp_data_in, dp_ld_a, dp_ld_b, dp_ld_c, dp_ld_x, dp_ld_r,
        input  dp_ld_alu_out, dp_alu_select_a, dp_alu_select_b, dp_alu_op,
        output dp_result
    );

endinterface

// File: rtl/poly_eval_scheduler_rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
//   Two-way arbiter with a one-bit round-robin pointer.
//   Ports:
//   - clk, reset : clock, synchronous active-high reset (pointer -> req0)
//   - valid[1:0] : request lines, bit N = requester N
//   - enable     : grants are only produced while high
//   - advance    : a grant was consumed this cycle; pointer moves away from
//                  the requester that was just served
//   - grant[1:0] : one-hot grant (or zero), combinational
//   Parameter FIXED_PRIORITY: 0 = pointer breaks ties, 1 = req0 wins ties.
// -----------------------------------------------------------------------------
module rr_arbiter_2 #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       enable,
    input  logic       advance,
    output logic [1:0] grant
);

    // ptr == 0 means requester 0 is favoured on a tie
    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ((FIXED_PRIORITY != 0) || !ptr) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // After serving requester 0 favour requester 1, and vice versa.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/poly_eval_scheduler.sv
// -----------------------------------------------------------------------------
// poly_eval_scheduler
//   Shares one external polynomial datapath between two requesters. An
//   accepted job (packed {x, C, B, A}) is loaded into the datapath over four
//   cycles, then a five-step compute sequence produces
//   R = A*x^2 + B*x + C (mod 256), which is returned with the requester id.
//   Accept at cycle T gives resp_valid at T+10.
//
//   Ports:
//   - clk, reset : clock, synchronous active-high reset (job in flight dropped)
//   - bus        : slave modport of poly_eval_scheduler_if (requests,
//                  response, datapath controls and datapath result)
//   - busy       : high in every state except IDLE
//   - jobs_done  : completed response handshakes, wraps at 2^CNT_W
//   - dbg_state  : current FSM state, for observation
//
//   Parameters:
//   - FIXED_PRIORITY : 0 = round-robin, 1 = req0 wins ties
//   - CNT_W          : width of jobs_done
// -----------------------------------------------------------------------------
module poly_eval_scheduler
    import poly_sched_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                reset,
    poly_eval_scheduler_if.slave bus,
    output logic                busy,
    output logic [CNT_W-1:0]    jobs_done,
    output state_t              dbg_state
);

    state_t              state;
    state_t              state_next;
    logic [OPND_W-1:0]   ops_q;
    logic                id_q;
    logic [1:0]          grant;
    logic                accept0;
    logic                accept1;
    logic                accept;
    logic                resp_fire;

    // ------------------------------------------------------------------
    // Arbitration: grants exist only in IDLE, so ready is never raised
    // while a job is in flight and at most one ready is high at a time.
    // ------------------------------------------------------------------
    rr_arbiter_2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid   ({bus.req1_valid, bus.req0_valid}),
        .enable  (state == IDLE),
        .advance (accept),
        .grant   (grant)
    );

    assign bus.req0_ready = (state == IDLE) && grant[0];
    assign bus.req1_ready = (state == IDLE) && grant[1];

    assign accept0   = bus.req0_valid && bus.req0_ready;
    assign accept1   = bus.req1_valid && bus.req1_ready;
    assign accept    = accept0 || accept1;
    assign resp_fire = (state == RESP) && bus.resp_ready;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Job capture: the bundle is held here for the whole load phase so the
    // requester is free to move on as soon as it is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ops_q <= '0;
            id_q  <= 1'b0;
        end else if (accept) begin
            ops_q <= accept1 ? bus.req1_operands : bus.req0_operands;
            id_q  <= accept1;
        end
    end

    // ------------------------------------------------------------------
    // Completed-job counter, counts response handshakes only
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            jobs_done <= '0;
        end else if (resp_fire) begin
            jobs_done <= jobs_done + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = LOAD_A;
            LOAD_A:  state_next = LOAD_B;
            LOAD_B:  state_next = LOAD_C;
            LOAD_C:  state_next = LOAD_X;
            LOAD_X:  state_next = CYC0;
            CYC0:    state_next = CYC1;
            CYC1:    state_next = CYC2;
            CYC2:    state_next = CYC3;
            CYC3:    state_next = CYC4;
            CYC4:    state_next = RESP;
            RESP:    if (bus.resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-state datapath controls and response outputs.
    // Compute sequence (Horner-like, all 8-bit truncating in the datapath):
    //   CYC0: A <= X*A      (A*x)
    //   CYC1: A <= X*A      (A*x^2)
    //   CYC2: B <= X*B      (B*x)
    //   CYC3: B <= A+B      (A*x^2 + B*x)
    //   CYC4: R <= B+C
    // ------------------------------------------------------------------
    always_comb begin
        bus.dp_data_in      = '0;
        bus.dp_ld_a         = 1'b0;
        bus.dp_ld_b         = 1'b0;
        bus.dp_ld_c         = 1'b0;
        bus.dp_ld_x         = 1'b0;
        bus.dp_ld_r         = 1'b0;
        bus.dp_ld_alu_out   = 1'b0;
        bus.dp_alu_select_a = SEL_A;
        bus.dp_alu_select_b = SEL_A;
        bus.dp_alu_op       = ALU_ADD;
        bus.resp_valid      = 1'b0;
        bus.resp_id         = 1'b0;
        bus.resp_data       = '0;
        case (state)
            LOAD_A: begin
                bus.dp_ld_a    = 1'b1;
                bus.dp_data_in = op_field(ops_q, OFF_A);
            end
            LOAD_B: begin
                bus.dp_ld_b    = 1'b1;
                bus.dp_data_in = op_field(ops_q, OFF_B);
            end
            LOAD_C: begin
                bus.dp_ld_c    = 1'b1;
                bus.dp_data_in = op_field(ops_q, OFF_C);
            end
            LOAD_X: begin
                bus.dp_ld_x    = 1'b1;
                bus.dp_data_in = op_field(ops_q, OFF_X);
            end
            CYC0, CYC1: begin
                bus.dp_ld_alu_out   = 1'b1;
                bus.dp_ld_a         = 1'b1;
                bus.dp_alu_select_a = SEL_X;
                bus.dp_alu_select_b = SEL_A;
                bus.dp_alu_op       = ALU_MUL;
            end
            CYC2: begin
                bus.dp_ld_alu_out   = 1'b1;
                bus.dp_ld_b         = 1'b1;
                bus.dp_alu_select_a = SEL_X;
                bus.dp_alu_select_b = SEL_B;
                bus.dp_alu_op       = ALU_MUL;
            end
            CYC3: begin
                bus.dp_ld_alu_out   = 1'b1;
                bus.dp_ld_b         = 1'b1;
                bus.dp_alu_select_a = SEL_A;
                bus.dp_alu_select_b = SEL_B;
                bus.dp_alu_op       = ALU_ADD;
            end
            CYC4: begin
                bus.dp_ld_r         = 1'b1;
                bus.dp_alu_select_a = SEL_B;
                bus.dp_alu_select_b = SEL_C;
                bus.dp_alu_op       = ALU_ADD;
            end
            RESP: begin
                // The datapath result register is untouched while waiting
                // here, so the response stays stable under backpressure.
                bus.resp_valid = 1'b1;
                bus.resp_id    = id_q;
                bus.resp_data  = bus.dp_result;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_poly_eval_scheduler.sv
`timescale 1ns/1ps
module tb_poly_eval_scheduler;
    import poly_sched_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    poly_eval_scheduler_if bus ();
    poly_eval_scheduler_if bus_fp ();

    logic        busy, busy_fp;
    logic [15:0] jobs_done;
    logic [2:0]  jobs_done_fp;
    state_t      dbg_state, dbg_state_fp;

    poly_eval_scheduler #(.FIXED_PRIORITY(0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .busy(busy), .jobs_done(jobs_done), .dbg_state(dbg_state)
    );

    poly_eval_scheduler #(.FIXED_PRIORITY(1), .CNT_W(3)) dut_fp (
        .clk(clk), .reset(reset), .bus(bus_fp),
        .busy(busy_fp), .jobs_done(jobs_done_fp), .dbg_state(dbg_state_fp)
    );

    // ---------------- datapath models ----------------
    function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c,
                                        input logic [7:0] x);
        case (s)
            2'b00:   return a;
            2'b01:   return b;
            2'b10:   return c;
            default: return x;
        endcase
    endfunction

    function automatic logic [7:0] alu(input logic op, input logic [7:0] p, input logic [7:0] q);
        logic [15:0] prod;
        logic [7:0]  sum;
        prod = p * q;
        sum  = p + q;
        return op ? prod[7:0] : sum;
    endfunction

    logic [7:0] m_a, m_b, m_c, m_x, m_r, m_alu;
    logic [7:0] f_a, f_b, f_c, f_x, f_r, f_alu;

    always_comb m_alu = alu(bus.dp_alu_op,
                            pick(bus.dp_alu_select_a, m_a, m_b, m_c, m_x),
                            pick(bus.dp_alu_select_b, m_a, m_b, m_c, m_x));
    always_comb f_alu = alu(bus_fp.dp_alu_op,
                            pick(bus_fp.dp_alu_select_a, f_a, f_b, f_c, f_x),
                            pick(bus_fp.dp_alu_select_b, f_a, f_b, f_c, f_x));

    always_ff @(posedge clk) begin
        if (bus.dp_ld_a) m_a <= bus.dp_ld_alu_out ? m_alu : bus.dp_data_in;
        if (bus.dp_ld_b) m_b <= bus.dp_ld_alu_out ? m_alu : bus.dp_data_in;
        if (bus.dp_ld_c) m_c <= bus.dp_ld_alu_out ? m_alu : bus.dp_data_in;
        if (bus.dp_ld_x) m_x <= bus.dp_ld_alu_out ? m_alu : bus.dp_data_in;
        if (bus.dp_ld_r) m_r <= m_alu;
        if (bus_fp.dp_ld_a) f_a <= bus_fp.dp_ld_alu_out ? f_alu : bus_fp.dp_data_in;
        if (bus_fp.dp_ld_b) f_b <= bus_fp.dp_ld_alu_out ? f_alu : bus_fp.dp_data_in;
        if (bus_fp.dp_ld_c) f_c <= bus_fp.dp_ld_alu_out ? f_alu : bus_fp.dp_data_in;
        if (bus_fp.dp_ld_x) f_x <= bus_fp.dp_ld_alu_out ? f_alu : bus_fp.dp_data_in;
        if (bus_fp.dp_ld_r) f_r <= f_alu;
    end

    assign bus.dp_result    = m_r;
    assign bus_fp.dp_result = f_r;

    // ---------------- reference polynomial ----------------
    function automatic logic [7:0] poly_ref(input logic [31:0] ops);
        logic [31:0] a, b, c, x, r;
        a = {24'd0, ops[7:0]};
        b = {24'd0, ops[15:8]};
        c = {24'd0, ops[23:16]};
        x = {24'd0, ops[31:24]};
        r = a * x * x + b * x + c;
        return r[7:0];
    endfunction

    // ---------------- scoreboard / driver state ----------------
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [8:0]  exp_q[$];
    bit          acc0, acc1, rdy, rv_prev;
    int          cyc, acc_cyc, first_resp_cyc, n_done;
    int          n_vec, n_err;

    function automatic logic [18:0] dp_pack0();
        return {bus.dp_ld_a, bus.dp_ld_b, bus.dp_ld_c, bus.dp_ld_x, bus.dp_ld_r,
                bus.dp_ld_alu_out, bus.dp_alu_select_a, bus.dp_alu_select_b,
                bus.dp_alu_op, bus.dp_data_in};
    endfunction

    task automatic set_idle();
        bus.req0_valid = 1'b0;    bus.req0_operands = '0;
        bus.req1_valid = 1'b0;    bus.req1_operands = '0;
        bus.resp_ready = 1'b1;
        bus_fp.req0_valid = 1'b0; bus_fp.req0_operands = '0;
        bus_fp.req1_valid = 1'b0; bus_fp.req1_operands = '0;
        bus_fp.resp_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        q0.delete(); q1.delete(); exp_q.delete();
        acc0 = 1'b0; acc1 = 1'b0; rv_prev = 1'b0; rdy = 1'b1;
        n_done = 0; cyc = 0; acc_cyc = -100; first_resp_cyc = -100;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock of the requester/consumer drivers plus response scoreboard.
    task automatic run_cycle(input int inst);
        logic       v0, v1, r0, r1, rv, rid;
        logic [7:0] rd;
        logic [8:0] e;
        @(negedge clk);
        if (acc0) void'(q0.pop_front());
        if (acc1) void'(q1.pop_front());
        v0 = (q0.size() > 0);
        v1 = (q1.size() > 0);
        set_idle();
        if (inst == 0) begin
            bus.req0_valid = v0; bus.req0_operands = v0 ? q0[0] : 32'd0;
            bus.req1_valid = v1; bus.req1_operands = v1 ? q1[0] : 32'd0;
            bus.resp_ready = rdy;
        end else begin
            bus_fp.req0_valid = v0; bus_fp.req0_operands = v0 ? q0[0] : 32'd0;
            bus_fp.req1_valid = v1; bus_fp.req1_operands = v1 ? q1[0] : 32'd0;
            bus_fp.resp_ready = rdy;
        end
        #1;
        r0  = (inst == 0) ? bus.req0_ready : bus_fp.req0_ready;
        r1  = (inst == 0) ? bus.req1_ready : bus_fp.req1_ready;
        rv  = (inst == 0) ? bus.resp_valid : bus_fp.resp_valid;
        rid = (inst == 0) ? bus.resp_id    : bus_fp.resp_id;
        rd  = (inst == 0) ? bus.resp_data  : bus_fp.resp_data;
        acc0 = v0 && r0;
        acc1 = v1 && r1;
        cyc++;
        n_vec++;
        if ((r0 & r1) !== 1'b0) begin
            n_err++;
            $display("FAIL both_ready: got req0_ready=%0b req1_ready=%0b, required at most one", r0, r1);
        end
        if (acc0 || acc1) acc_cyc = cyc;
        if (rv && !rv_prev) first_resp_cyc = cyc;
        rv_prev = rv;
        if (rv && rdy) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL resp_unexpected: got id=%0d data=%02h, required no response", rid, rd);
            end else begin
                e = exp_q.pop_front();
                if ({rid, rd} !== e) begin
                    n_err++;
                    $display("FAIL resp: got id=%0d data=%02h, required id=%0d data=%02h",
                             rid, rd, e[8], e[7:0]);
                end
            end
            n_done++;
        end
    endtask

    task automatic wait_done(input int inst, input int target, input int budget);
        int n;
        n = 0;
        while (n_done < target && n < budget) begin
            run_cycle(inst);
            n++;
        end
        n_vec++;
        if (n_done < target) begin
            n_err++;
            $display("FAIL timeout: got %0d responses, required %0d within %0d cycles", n_done, target, budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        #1;
        n_vec++;
        if ({busy, bus.resp_valid, bus.req0_ready, bus.req1_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got busy=%0b resp_valid=%0b rdy0=%0b rdy1=%0b, required 0",
                     busy, bus.resp_valid, bus.req0_ready, bus.req1_ready);
        end
        n_vec++;
        if (jobs_done !== 16'd0 || jobs_done_fp !== 3'd0) begin
            n_err++;
            $display("FAIL reset_jobs_done: got %0d/%0d, required 0/0", jobs_done, jobs_done_fp);
        end
        n_vec++;
        if (dbg_state !== IDLE || dbg_state_fp !== IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d/%0d, required IDLE", dbg_state, dbg_state_fp);
        end
        n_vec++;
        if (dp_pack0() !== 19'd0) begin
            n_err++;
            $display("FAIL reset_dp: got %05h, required 00000", dp_pack0());
        end
    endtask

    task automatic test_single();
        logic [31:0] ops;
        logic [18:0] exp_dp;
        int          rel, n;
        do_reset();
        ops = {8'd5, 8'd4, 8'd3, 8'd2};
        q0.push_back(ops);
        exp_q.push_back({1'b0, 8'h45});
        n = 0;
        while (n_done < 1 && n < 40) begin
            run_cycle(0);
            n++;
            rel = cyc - acc_cyc;
            if (rel >= 0 && rel <= 10) begin
                case (rel)
                    1:       exp_dp = {6'b100000, 2'b00, 2'b00, 1'b0, ops[7:0]};
                    2:       exp_dp = {6'b010000, 2'b00, 2'b00, 1'b0, ops[15:8]};
                    3:       exp_dp = {6'b001000, 2'b00, 2'b00, 1'b0, ops[23:16]};
                    4:       exp_dp = {6'b000100, 2'b00, 2'b00, 1'b0, ops[31:24]};
                    5, 6:    exp_dp = {6'b100001, 2'b11, 2'b00, 1'b1, 8'h00};
                    7:       exp_dp = {6'b010001, 2'b11, 2'b01, 1'b1, 8'h00};
                    8:       exp_dp = {6'b010001, 2'b00, 2'b01, 1'b0, 8'h00};
                    9:       exp_dp = {6'b000010, 2'b01, 2'b10, 1'b0, 8'h00};
                    default: exp_dp = 19'd0;
                endcase
                n_vec++;
                if (dp_pack0() !== exp_dp) begin
                    n_err++;
                    $display("FAIL dp_seq_%0d: got %05h, required %05h", rel, dp_pack0(), exp_dp);
                end
            end
        end
        n_vec++;
        if (n_done != 1) begin
            n_err++;
            $display("FAIL single_timeout: got %0d responses, required 1", n_done);
        end
        n_vec++;
        if (first_resp_cyc - acc_cyc != 10) begin
            n_err++;
            $display("FAIL latency: got %0d cycles, required 10", first_resp_cyc - acc_cyc);
        end
        run_cycle(0);
        n_vec++;
        if (jobs_done !== 16'd1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_done: got jobs_done=%0d busy=%0b, required 1/0", jobs_done, busy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        q1.push_back(32'hFFFF_FFFF);
        exp_q.push_back({1'b1, 8'hFF});
        q1.push_back({8'd4, 8'd0, 8'd0, 8'd16});
        exp_q.push_back({1'b1, 8'h00});
        wait_done(0, 2, 60);
        run_cycle(0);
        n_vec++;
        if (jobs_done !== 16'd2) begin
            n_err++;
            $display("FAIL wrap_jobs_done: got %0d, required 2", jobs_done);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] a[4];
        logic [31:0] b[4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a[i] = $urandom;
            b[i] = $urandom;
            q0.push_back(a[i]);
            q1.push_back(b[i]);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, poly_ref(a[i])});
            exp_q.push_back({1'b1, poly_ref(b[i])});
        end
        wait_done(0, 8, 150);
        run_cycle(0);
        n_vec++;
        if (jobs_done !== 16'd8) begin
            n_err++;
            $display("FAIL rr_jobs_done: got %0d, required 8", jobs_done);
        end
    endtask

    task automatic test_fixed_priority();
        logic [31:0] a[4];
        logic [31:0] b[4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a[i] = $urandom;
            b[i] = $urandom;
            q0.push_back(a[i]);
            q1.push_back(b[i]);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, poly_ref(a[i])});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, poly_ref(b[i])});
        wait_done(1, 7, 130);
        run_cycle(1);
        n_vec++;
        if (jobs_done_fp !== 3'd7) begin
            n_err++;
            $display("FAIL fp_jobs_done_7: got %0d, required 7", jobs_done_fp);
        end
        wait_done(1, 8, 30);
        run_cycle(1);
        n_vec++;
        if (jobs_done_fp !== 3'd0) begin
            n_err++;
            $display("FAIL fp_jobs_done_wrap: got %0d, required 0", jobs_done_fp);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        logic [7:0]  hold_d;
        logic        hold_id;
        int          n;
        do_reset();
        a = $urandom;
        b = $urandom;
        q0.push_back(a);
        q1.push_back(b);
        exp_q.push_back({1'b0, poly_ref(a)});
        exp_q.push_back({1'b1, poly_ref(b)});
        rdy = 1'b0;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 30) begin
            run_cycle(0);
            n++;
        end
        n_vec++;
        if (bus.resp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_no_resp: got resp_valid=%0b, required 1", bus.resp_valid);
        end
        hold_d  = bus.resp_data;
        hold_id = bus.resp_id;
        repeat (20) begin
            run_cycle(0);
            n_vec++;
            if ({bus.resp_valid, bus.resp_id, bus.resp_data, bus.req0_ready, bus.req1_ready}
                !== {1'b1, hold_id, hold_d, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold: got v=%0b id=%0d d=%02h rdy0=%0b rdy1=%0b, required v=1 id=%0d d=%02h rdy0=0 rdy1=0",
                         bus.resp_valid, bus.resp_id, bus.resp_data, bus.req0_ready, bus.req1_ready,
                         hold_id, hold_d);
            end
        end
        rdy = 1'b1;
        run_cycle(0);
        run_cycle(0);
        n_vec++;
        if ({busy, bus.req1_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_release: got busy=%0b req1_ready=%0b, required 0/1", busy, bus.req1_ready);
        end
        wait_done(0, 2, 40);
    endtask

    task automatic test_reset_mid_job();
        logic [31:0] a;
        int          n;
        do_reset();
        a = $urandom;
        q0.push_back(a);
        exp_q.push_back({1'b0, poly_ref(a)});
        wait_done(0, 1, 40);
        q0.push_back($urandom);
        n = 0;
        while (dbg_state !== CYC2 && n < 20) begin
            run_cycle(0);
            n++;
        end
        n_vec++;
        if (dbg_state !== CYC2) begin
            n_err++;
            $display("FAIL mid_reach_cyc2: got state %0d, required CYC2", dbg_state);
        end
        reset = 1'b1;
        q0.delete();
        set_idle();
        acc0 = 1'b0;
        acc1 = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if ({dbg_state, busy, bus.resp_valid} !== {IDLE, 1'b0, 1'b0} || jobs_done !== 16'd0) begin
            n_err++;
            $display("FAIL mid_reset: got state=%0d busy=%0b resp_valid=%0b jobs_done=%0d, required IDLE/0/0/0",
                     dbg_state, busy, bus.resp_valid, jobs_done);
        end
        reset   = 1'b0;
        rv_prev = 1'b0;
        n_done  = 0;
        q0.push_back({8'd1, 8'd1, 8'd1, 8'd1});
        exp_q.push_back({1'b0, 8'h03});
        wait_done(0, 1, 40);
    endtask

    // ---------------- main ----------------
    initial begin
        reset = 1'b1;
        set_idle();
        rdy   = 1'b1;
        n_vec = 0;
        n_err = 0;
        acc0  = 1'b0;
        acc1  = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
